// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: bus widths and the digit pattern set.
// Bit 0 is segment a, bit 6 is segment g, active-high.
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_monitor_if.sv
// Segment bus into the monitor plus its decoded/checked results.
// master: the side driving the pins and observing results; slave: the monitor.
interface seg7_monitor_if;
    import seg7_pkg::*;

    logic [SEG_W-1:0]   seg_in;
    logic [DIGIT_W-1:0] digit;
    logic               digit_valid;
    logic               illegal;
    logic               seq_err;
    logic               period_err;
    logic               locked;
    logic [23:0]        last_period;
    logic [7:0]         err_count;

    modport master (
        output seg_in,
        input  digit, digit_valid, illegal, seq_err, period_err,
        input  locked, last_period, err_count
    );

    modport slave (
        input  seg_in,
        output digit, digit_valid, illegal, seq_err, period_err,
        output locked, last_period, err_count
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational pattern-to-digit decoder; anything outside the table
// (blank included) is flagged as not legal.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]   seg,
    output logic [DIGIT_W-1:0] digit,
    output logic               legal
);

    // Table lookup with a safe default for unknown patterns
    always_comb begin
        digit = '0;
        legal = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_monitor.sv
// Receive-side checker for the seconds display: synchronizes and debounces
// the segment bus, decodes each newly stable pattern, and checks digit order
// and accept-to-accept spacing against the transmitter's prescaler.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter logic [23:0] MAX_COUNT     = 24'd10_000_000,
    parameter logic [23:0] TOLERANCE     = 24'd1_000,
    parameter int          STABLE_CYCLES = 4,
    parameter logic [3:0]  LAST_DIGIT    = 4'd8
) (
    input  logic          clk,
    input  logic          reset,
    seg7_monitor_if.slave bus
);

    localparam int          SYNC_STAGES = 2;
    localparam logic [3:0]  STAB_LAST   = 4'(STABLE_CYCLES - 1);
    // Nominal distance widened so MAX_COUNT = all-ones cannot wrap
    localparam logic [24:0] PERIOD_NOM  = {1'b0, MAX_COUNT} + 25'd1;

    logic [SEG_W-1:0]   sync_q [SYNC_STAGES];
    logic [SEG_W-1:0]   s2;

    logic [SEG_W-1:0]   cand_q, cand_d;
    logic [3:0]         stab_q, stab_d;
    logic [SEG_W-1:0]   acc_q, acc_d;
    logic [23:0]        period_q, period_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;
    logic               seq_q, seq_d;
    logic               per_q, per_d;
    logic               locked_q, locked_d;
    logic [23:0]        lp_q, lp_d;
    logic [7:0]         err_q, err_d;

    logic [DIGIT_W-1:0] dec_digit;
    logic               dec_legal;
    logic               accept;
    logic [DIGIT_W-1:0] exp_next;
    logic [24:0]        period_ext;
    logic [24:0]        deviation;
    logic               period_bad;
    logic               any_err;

    // Synchronizer chain; the last stage is the sampled bus the filter sees
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous pins
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= '0;
                    else       sync_q[gi] <= bus.seg_in;
                end
            end else begin : g_rest
                // Later stages settle metastability
                always_ff @(posedge clk) begin
                    if (reset) sync_q[gi] <= '0;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign s2 = sync_q[SYNC_STAGES-1];

    seg7_decode u_decode (
        .seg   (cand_q),
        .digit (dec_digit),
        .legal (dec_legal)
    );

    // A pattern is taken once: it must be stable long enough and differ from the last one taken
    assign accept   = (stab_q == STAB_LAST) && (s2 == cand_q) && (cand_q != acc_q);
    assign exp_next = (digit_q == LAST_DIGIT) ? '0 : digit_q + 4'd1;

    // Absolute deviation of the measured period from nominal
    always_comb begin
        period_ext = {1'b0, period_q};
        deviation  = '0;
        if (period_ext >= PERIOD_NOM) deviation = period_ext - PERIOD_NOM;
        else                          deviation = PERIOD_NOM - period_ext;
        period_bad = deviation > {1'b0, TOLERANCE};
    end

    // Filter, decode-check and counter next-state
    always_comb begin
        cand_d    = cand_q;
        stab_d    = stab_q;
        acc_d     = acc_q;
        period_d  = period_q;
        digit_d   = digit_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        seq_d     = 1'b0;
        per_d     = 1'b0;
        locked_d  = locked_q;
        lp_d      = lp_q;
        err_d     = err_q;
        any_err   = 1'b0;

        if (s2 != cand_q) begin
            cand_d = s2;
            stab_d = '0;
        end else if (stab_q < STAB_LAST) begin
            stab_d = stab_q + 4'd1;
        end

        if (accept) begin
            acc_d = cand_q;
            if (dec_legal) begin
                digit_d  = dec_digit;
                valid_d  = 1'b1;
                lp_d     = period_q;
                period_d = 24'd1;
                // Order and spacing are only meaningful against a trusted previous digit
                if (locked_q) begin
                    seq_d = (dec_digit != exp_next);
                    per_d = period_bad;
                end
                locked_d = 1'b1;
            end else begin
                // Illegal accepts leave the period measurement running untouched
                illegal_d = 1'b1;
                locked_d  = 1'b0;
            end
        end else if (period_q != 24'hFF_FFFF) begin
            period_d = period_q + 24'd1;
        end

        // One count per erroneous accept, however many flags it raised
        any_err = illegal_d | seq_d | per_d;
        if (any_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q    <= SEG_BLANK;
            stab_q    <= '0;
            acc_q     <= SEG_BLANK;
            period_q  <= '0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            seq_q     <= 1'b0;
            per_q     <= 1'b0;
            locked_q  <= 1'b0;
            lp_q      <= '0;
            err_q     <= '0;
        end else begin
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            acc_q     <= acc_d;
            period_q  <= period_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            seq_q     <= seq_d;
            per_q     <= per_d;
            locked_q  <= locked_d;
            lp_q      <= lp_d;
            err_q     <= err_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.seq_err     = seq_q;
    assign bus.period_err  = per_q;
    assign bus.locked      = locked_q;
    assign bus.last_period = lp_q;
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor with a shortened prescaler (MAX_COUNT=100).
module tb_seg7_monitor;
    import seg7_pkg::*;

    localparam logic [23:0] MC  = 24'd100;
    localparam logic [23:0] TOL = 24'd10;
    localparam int          SC  = 4;
    localparam logic [3:0]  LD  = 4'd8;
    localparam int          NV  = 18;
    // Drive at a negedge to registered pulse: STABLE_CYCLES+3 posedges
    localparam int          LAT = SC + 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_monitor_if bus ();

    seg7_monitor #(
        .MAX_COUNT     (MC),
        .TOLERANCE     (TOL),
        .STABLE_CYCLES (SC),
        .LAST_DIGIT    (LD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Event monitor: records every accept pulse and when it happened
    int         ev_n = 0;
    logic [3:0] ev_flags = '0;
    int         ev_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.digit_valid || bus.illegal) begin
            ev_n     = ev_n + 1;
            ev_flags = {bus.digit_valid, bus.illegal, bus.seq_err, bus.period_err};
            ev_cyc   = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " digit"},       32'(bus.digit),       0);
        chk({tag, " digit_valid"}, 32'(bus.digit_valid), 0);
        chk({tag, " illegal"},     32'(bus.illegal),     0);
        chk({tag, " seq_err"},     32'(bus.seq_err),     0);
        chk({tag, " period_err"},  32'(bus.period_err),  0);
        chk({tag, " locked"},      32'(bus.locked),      0);
        chk({tag, " last_period"}, 32'(bus.last_period), 0);
        chk({tag, " err_count"},   32'(bus.err_count),   0);
    endtask

    // flags = {digit_valid, illegal, seq_err, period_err}
    typedef struct {
        logic [6:0]  seg;
        int          hold;
        logic [3:0]  flags;
        logic [3:0]  dig;
        logic        lock;
        logic        chk_lp;
        logic [23:0] lp;
        logic [7:0]  err;
    } vec_t;

    vec_t vt [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time expired before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int dc;
        int first;
        int nvalid;

        // Clean sequence 0..8,0 then skip, period and illegal cases
        vt[0]  = '{7'h3F, 101, 4'b1000, 4'd0, 1'b1, 1'b0, 24'd0,   8'd0};
        vt[1]  = '{7'h06, 101, 4'b1000, 4'd1, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[2]  = '{7'h5B, 101, 4'b1000, 4'd2, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[3]  = '{7'h4F, 101, 4'b1000, 4'd3, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[4]  = '{7'h66, 101, 4'b1000, 4'd4, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[5]  = '{7'h6D, 101, 4'b1000, 4'd5, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[6]  = '{7'h7D, 101, 4'b1000, 4'd6, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[7]  = '{7'h07, 101, 4'b1000, 4'd7, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[8]  = '{7'h7F, 101, 4'b1000, 4'd8, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[9]  = '{7'h3F, 101, 4'b1000, 4'd0, 1'b1, 1'b1, 24'd101, 8'd0};
        vt[10] = '{7'h06, 101, 4'b1000, 4'd1, 1'b1, 1'b1, 24'd101, 8'd0};
        // skip 2: sequence error
        vt[11] = '{7'h4F, 101, 4'b1010, 4'd3, 1'b1, 1'b1, 24'd101, 8'd1};
        vt[12] = '{7'h66,  60, 4'b1000, 4'd4, 1'b1, 1'b1, 24'd101, 8'd1};
        // 60-cycle distance: period error
        vt[13] = '{7'h6D, 105, 4'b1001, 4'd5, 1'b1, 1'b1, 24'd60,  8'd2};
        // 105-cycle distance: within tolerance
        vt[14] = '{7'h7D, 101, 4'b1000, 4'd6, 1'b1, 1'b1, 24'd105, 8'd2};
        // illegal pattern: digit and last_period held, unlocked
        vt[15] = '{7'h55, 101, 4'b0100, 4'd6, 1'b0, 1'b1, 24'd105, 8'd3};
        // first legal after illegal: no checks; counter held one cycle on the illegal accept
        vt[16] = '{7'h07,  50, 4'b1000, 4'd7, 1'b1, 1'b1, 24'd201, 8'd3};
        // seq and period error together count once
        vt[17] = '{7'h5B, 101, 4'b1011, 4'd2, 1'b1, 1'b1, 24'd50,  8'd4};

        // Reset state, and a blank display through reset gives no event
        reset      = 1'b1;
        bus.seg_in = SEG_BLANK;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("blank no event", 32'(ev_n), 0);
        $display("reset: outputs zero, events=%0d", ev_n);

        for (int i = 0; i < NV; i++) begin
            n0 = ev_n;
            dc = cyc;
            bus.seg_in = vt[i].seg;
            repeat (vt[i].hold) @(negedge clk);
            chk($sformatf("v%0d events", i),  32'(ev_n - n0),        1);
            chk($sformatf("v%0d flags", i),   32'(ev_flags),         32'(vt[i].flags));
            chk($sformatf("v%0d latency", i), 32'(ev_cyc - dc),      LAT);
            chk($sformatf("v%0d digit", i),   32'(bus.digit),        32'(vt[i].dig));
            chk($sformatf("v%0d locked", i),  32'(bus.locked),       32'(vt[i].lock));
            chk($sformatf("v%0d err", i),     32'(bus.err_count),    32'(vt[i].err));
            if (vt[i].chk_lp)
                chk($sformatf("v%0d last_period", i), 32'(bus.last_period), 32'(vt[i].lp));
            $display("vec %0d: seg=%h hold=%0d flags=%b digit=%0d locked=%0d lp=%0d err=%0d",
                     i, vt[i].seg, vt[i].hold, ev_flags, bus.digit, bus.locked,
                     bus.last_period, bus.err_count);
        end

        // Glitch of 3 synchronized cycles inside a held 5B
        n0 = ev_n;
        bus.seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        bus.seg_in = 7'h5B;
        repeat (20) @(negedge clk);
        chk("glitch events", 32'(ev_n - n0),      0);
        chk("glitch digit",  32'(bus.digit),      2);
        chk("glitch err",    32'(bus.err_count),  4);
        chk("glitch locked", 32'(bus.locked),     1);
        chk("glitch lp",     32'(bus.last_period), 50);
        $display("glitch: events=%0d digit=%0d", ev_n - n0, bus.digit);

        // 300 illegal accepts saturate the error count
        n0 = ev_n;
        for (int k = 0; k < 300; k++) begin
            bus.seg_in = (k % 2 == 0) ? 7'h55 : SEG_BLANK;
            repeat (8) @(negedge clk);
        end
        chk("sat events", 32'(ev_n - n0),     300);
        chk("sat flags",  32'(ev_flags),      32'(4'b0100));
        chk("sat err",    32'(bus.err_count), 255);
        chk("sat locked", 32'(bus.locked),    0);
        chk("sat digit",  32'(bus.digit),     2);
        $display("saturate: events=%0d err=%0d", ev_n - n0, bus.err_count);

        // Reset mid-hold with 3F driven, then the accept of 0 after release
        bus.seg_in = 7'h3F;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("midreset");
        reset  = 1'b0;
        first  = 0;
        nvalid = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.digit_valid) begin
                nvalid = nvalid + 1;
                if (first == 0) first = k;
            end
        end
        chk("post-reset accept edge", 32'(first),         LAT);
        chk("post-reset pulses",      32'(nvalid),        1);
        chk("post-reset digit",       32'(bus.digit),     0);
        chk("post-reset locked",      32'(bus.locked),    1);
        chk("post-reset err",         32'(bus.err_count), 0);
        $display("post-reset: accept at edge %0d digit=%0d locked=%0d", first, bus.digit, bus.locked);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Receive-side checker for the seven-segment seconds display. It samples a 7-bit segment bus from pins, filters glitches, and decodes each stable pattern back to a digit. It checks that successive digits follow the counter sequence and arrive at the expected interval. It sits on the input side of a loop-back bench or a second tile, and reports the decoded digit, error pulses and a saturating error count.

## Interface
- `MAX_COUNT`, default 24'd10_000_000: the transmitter's prescaler terminal count. The expected accept-to-accept distance is MAX_COUNT+1 cycles.
- `TOLERANCE`, default 24'd1_000: the allowed absolute deviation of the measured period, in cycles.
- `STABLE_CYCLES`, default 4: the number of consecutive identical synchronized samples needed to accept a pattern. Legal range is 2..15.
- `LAST_DIGIT`, default 4'd8: the highest digit in the sequence. The expected sequence is 0..LAST_DIGIT, then 0.
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `seg_in`  in  7: the segment bus. Bit 0 is segment a and bit 6 is segment g; active-high. It is asynchronous to `clk`.
- `digit`  out  4: the last legally decoded digit.
- `digit_valid`  out  1: a one-cycle pulse on each legal accept.
- `illegal`  out  1: a one-cycle pulse when an accepted pattern is not in the digit table.
- `seq_err`  out  1: a one-cycle pulse when a legal digit is not the expected successor.
- `period_err`  out  1: a one-cycle pulse when the accept distance is outside tolerance.
- `locked`  out  1: high once a legal digit has been seen; cleared by `illegal`.
- `last_period`  out  24: the accept-to-accept distance of the latest legal accept.
- `err_count`  out  8: the number of error events, saturating at 255.

## Operation
- **Synchronizer.** Two-flop synchronizer on `seg_in`, giving `s2`.
- **Stability filter.**
  - If `s2` ≠ `cand`: `cand` <= `s2` and `stab_cnt` <= 0.
  - Else if `stab_cnt` < STABLE_CYCLES-1: increment `stab_cnt`.
  - Accept when `stab_cnt` == STABLE_CYCLES-1, `s2` == `cand` and `cand` ≠ `acc`. On accept, `acc` <= `cand`.
  - A pattern is accepted once per change. A held pattern never re-fires.
- **Decode table.** 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other value is illegal, including 7'h00.
- **Illegal accept.**
  - Pulse `illegal`, clear `locked`, increment `err_count`.
  - `digit` and `last_period` are unchanged, and `period_cnt` is not cleared.
- **Legal accept.**
  - Update `digit`, pulse `digit_valid`, set `last_period` <= `period_cnt`, clear `period_cnt` to 1.
  - If `locked` was already set:
    - `seq_err` if the decoded value ≠ (`digit`==LAST_DIGIT ? 0 : `digit`+1).
    - `period_err` if \|`period_cnt` − (MAX_COUNT+1)\| > TOLERANCE.
  - Then set `locked`.
- **Period counter.** `period_cnt` is 24 bits. It increments every non-accept cycle and saturates at 24'hFFFFFF.
- **Error counting.** `err_count` increments by exactly 1 per accept carrying any error. Simultaneous `seq_err` and `period_err` count once. Saturates at 8'hFF.
- **Reset.**
  - Outputs: all outputs 0.
  - Internal state: `acc` = 7'h00, `cand` = 7'h00, `stab_cnt` = 0, `period_cnt` = 0, synchronizer flops 0.
  - A display held blank through reset produces no event.
- **Reset mid-operation.** An asserted `reset` overrides any accept in the same cycle. Checking restarts unlocked.

## Timing
- A `seg_in` change settling before edge E0 produces its accept pulses, registered, after edge E0+STABLE_CYCLES+2. With the defaults that is 6 edges, visible in the following cycle.
- A glitch lasting fewer than STABLE_CYCLES synchronized cycles produces no accept.
- The filter delay is identical for every accept, so `last_period` equals the true transmitter distance.
- All outputs are registered. Pulses are exactly 1 cycle wide. `digit` and `digit_valid` update on the same edge.

## Structure
- Package `seg7_pkg`: the ten segment pattern constants, the `SEG_BLANK` constant, and the digit/segment widths. This is shared with the transmit-side `seg7`.
- Sub-module `seg7_decode`: combinational, 7-bit pattern in, outputs `digit[3:0]` and `legal`.
- Everything else (synchronizer, filter, checker, counters) lives in `seg7_monitor`.

## Test plan
- **Clean sequence.** Drive 3F, 06, 5B, … 7F, 3F, each held MAX_COUNT+1 cycles, with MAX_COUNT=100 for simulation. Expect `digit_valid` per change, `digit` 0..8..0, no errors, and `last_period` = 101 after the second accept.
- **Glitch.** Pulse `seg_in` to 7'h7F for 3 cycles inside a held 3F (STABLE_CYCLES=4). Expect no accept and all outputs unchanged.
- **Skip.** Sequence 0, 1, 3. Expect `seq_err` on the accept of 3, `err_count`=1, `digit`=3, `locked` still 1.
- **Period.** The digit-2 accept arrives 60 cycles after digit 1 (MAX_COUNT=100, TOLERANCE=10). Expect `period_err`, `err_count`+1, `last_period`=60. A 105-cycle distance gives no error.
- **Illegal.** Drive 7'h55. Expect `illegal`, `locked`=0, `digit` held. The next legal digit gives no `seq_err` and no `period_err`, and `locked`=1.
- **Saturation and reset.** 300 illegal events give `err_count`=255. Asserting `reset` mid-hold zeroes all outputs. With 3F held through reset, expect an accept of 0 STABLE_CYCLES+3 edges after `reset` falls.
